// File: rtl/onchip_mem_dma.sv
// Memory-port engine for the on-chip frame memory: FILL, COPY and CHECKSUM jobs
// over a contiguous, wrapping word range with start/busy/done handshake and abort.
module onchip_mem_dma #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int SUM_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_start,
  input  logic [1:0]        cmd_mode,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [SUM_W-1:0]  result,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);
  localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_CP_RD, S_CP_WAIT, S_CP_WR, S_SUM, S_DRAIN, S_END
  } state_t;

  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [ADDR_W:0]   r_len, r_idx;
  logic [DATA_W-1:0] r_fill, r_rdata;
  logic [WC_W-1:0]   r_wcnt;
  logic [RD_LAT-1:0] r_vld, w_vld_nxt;
  logic [SUM_W-1:0]  r_acc, r_result, w_acc_nxt;
  logic              r_err;
  logic              w_run, w_accept, w_bad, w_last, w_abort, w_issue, w_wait_done;

  assign w_run       = (r_state != S_IDLE) && (r_state != S_END);
  assign w_accept    = (r_state == S_IDLE) && cmd_start;
  assign w_bad       = (cmd_mode == 2'd3) || (cmd_len[ADDR_W] && (|cmd_len[ADDR_W-1:0]));
  assign w_last      = (r_idx == r_len - (ADDR_W+1)'(1));
  assign w_abort     = cmd_abort && w_run;
  assign w_issue     = (r_state == S_SUM);
  assign w_wait_done = (r_wcnt == WC_W'(RD_LAT-1));
  // Top bit of the valid pipe marks the cycle in which a checksum read returns.
  assign w_acc_nxt   = r_vld[RD_LAT-1] ? r_acc + SUM_W'(mem_readdata) : r_acc;

  if (RD_LAT == 1) begin : g_vld1
    assign w_vld_nxt = w_issue;
  end else begin : g_vldn
    assign w_vld_nxt = {r_vld[RD_LAT-2:0], w_issue};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (cmd_start) begin
        if (w_bad || cmd_len == '0) w_nxt = S_END;
        else if (cmd_mode == 2'd0)  w_nxt = S_FILL;
        else if (cmd_mode == 2'd1)  w_nxt = S_CP_RD;
        else                        w_nxt = S_SUM;
      end
      S_FILL:    if (w_last) w_nxt = S_END;
      S_CP_RD:   w_nxt = S_CP_WAIT;
      S_CP_WAIT: if (w_wait_done) w_nxt = S_CP_WR;
      S_CP_WR:   w_nxt = w_last ? S_END : S_CP_RD;
      S_SUM:     if (w_last) w_nxt = S_DRAIN;
      S_DRAIN:   if (w_vld_nxt == '0) w_nxt = S_END;
      S_END:     w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
    if (w_abort) w_nxt = S_END;
  end

  always_comb begin
    busy           = w_run;
    done           = (r_state == S_END);
    error          = r_err;
    result         = r_result;
    mem_clken      = w_run;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    case (r_state)
      S_FILL: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = r_dst + r_idx[ADDR_W-1:0];
        mem_writedata  = r_fill;
      end
      S_CP_RD, S_SUM: begin
        mem_chipselect = 1'b1;
        mem_address    = r_src + r_idx[ADDR_W-1:0];
      end
      S_CP_WR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = r_dst + r_idx[ADDR_W-1:0];
        mem_writedata  = r_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_src <= '0; r_dst <= '0; r_len <= '0; r_idx <= '0; r_fill <= '0;
      r_rdata <= '0; r_wcnt <= '0; r_vld <= '0; r_acc <= '0; r_result <= '0; r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src  <= cmd_src;
        r_dst  <= cmd_dst;
        r_len  <= cmd_len;
        r_fill <= cmd_fill;
        r_idx  <= '0;
        r_acc  <= '0;
        r_err  <= w_bad;
      end else begin
        if (w_abort) r_err <= 1'b1;
        if ((r_state == S_FILL || r_state == S_CP_WR || r_state == S_SUM) && !w_last)
          r_idx <= r_idx + (ADDR_W+1)'(1);
        if (r_state == S_SUM || r_state == S_DRAIN) r_acc <= w_acc_nxt;
      end
      if (r_state == S_CP_RD)        r_wcnt <= '0;
      else if (r_state == S_CP_WAIT) r_wcnt <= r_wcnt + WC_W'(1);
      if (r_state == S_CP_WAIT && w_wait_done) r_rdata <= mem_readdata;
      // Pipe is flushed whenever the job leaves the checksum states, discarding returns.
      r_vld <= (w_nxt == S_SUM || w_nxt == S_DRAIN) ? w_vld_nxt : '0;
      if (r_state == S_DRAIN && w_nxt == S_END && !w_abort) r_result <= w_acc_nxt;
    end
  end
endmodule

// File: tb/tb_onchip_mem_dma.sv
// Bench for onchip_mem_dma: memory model plus job-level reference (traces, memory image, checksum).
module tb_onchip_mem_dma;
  localparam int AW = 15, DW = 8, RL = 2, SW = 16;
  localparam int MSZ = 1 << AW;
  localparam int LIMIT = 2000;

  logic clk = 0, rst_n = 0;
  logic c_start = 0, c_abort = 0;
  logic [1:0] c_mode = 0;
  logic [AW-1:0] c_src = 0, c_dst = 0;
  logic [AW:0] c_len = 0;
  logic [DW-1:0] c_fill = 0;
  logic busy, done, error, mem_chipselect, mem_clken, mem_write;
  logic [SW-1:0] result;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_mem_dma #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .SUM_W(SW)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .cmd_start(c_start), .cmd_mode(c_mode),
    .cmd_src(c_src), .cmd_dst(c_dst), .cmd_len(c_len), .cmd_fill(c_fill), .cmd_abort(c_abort),
    .busy(busy), .done(done), .error(error), .result(result), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_clken(mem_clken), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata));

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 167) ^ (a >> 5) ^ 90);
  endfunction

  // Memory with RL-cycle read latency; non-returning cycles carry garbage.
  logic [DW-1:0] mem [MSZ];
  logic [DW-1:0] refmem [MSZ];
  logic [DW-1:0] rd_pipe [RL];
  bit mem_init = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int a = 0; a < MSZ; a++) mem[a] <= init_val(a);
      mem_init <= 1;
    end else if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_chipselect && !mem_write) ? mem[mem_address] : DW'($urandom);
  end
  assign mem_readdata = rd_pipe[RL-1];

  typedef struct { int k; int addr; bit wr; int data; } acc_t;
  acc_t exp_q[$], obs_q[$];
  int n_cmp = 0, n_bad = 0;
  int o_done_k, o_err, o_busy1, o_busy_done, o_clk_bad;
  logic [SW-1:0] o_res;
  int e_done_k, e_err;
  logic [SW-1:0] ref_res = 0;

  // Job-level reference: cycle of every access relative to the start cycle, final memory, checksum.
  task automatic model(input int mode, src, dst, len, fill, abort_at);
    int nd, kr, kw, a;
    bit bad, ab;
    logic [SW-1:0] sum;
    logic [DW-1:0] d;
    exp_q.delete();
    bad = (mode == 3) || (len > MSZ);
    if (bad || len == 0) begin e_done_k = 1; e_err = bad; return; end
    nd = (mode == 0) ? len + 1 : (mode == 1) ? 1 + len * (RL + 2) : len + RL + 1;
    ab = (abort_at > 0) && (abort_at < nd);
    sum = 0;
    for (int i = 0; i < len; i++) begin
      if (mode == 0) begin
        a = (dst + i) % MSZ;
        if (!ab || i + 1 <= abort_at) begin
          exp_q.push_back('{i + 1, a, 1'b1, fill});
          refmem[a] = DW'(fill);
        end
      end else if (mode == 1) begin
        kr = 1 + i * (RL + 2);
        kw = kr + RL + 1;
        d = refmem[(src + i) % MSZ];
        a = (dst + i) % MSZ;
        if (!ab || kr <= abort_at) exp_q.push_back('{kr, (src + i) % MSZ, 1'b0, 0});
        if (!ab || kw <= abort_at) begin
          exp_q.push_back('{kw, a, 1'b1, int'(d)});
          refmem[a] = d;
        end
      end else begin
        if (!ab || i + 1 <= abort_at) exp_q.push_back('{i + 1, (src + i) % MSZ, 1'b0, 0});
        sum = sum + SW'(refmem[(src + i) % MSZ]);
      end
    end
    if (mode == 2 && !ab) ref_res = sum;
    e_done_k = ab ? abort_at + 1 : nd;
    e_err = ab ? 1 : 0;
  endtask

  task automatic run_job(input int mode, src, dst, len, fill, abort_at, restart_at);
    model(mode, src, dst, len, fill, abort_at);
    @(negedge clk);
    c_mode = 2'(mode); c_src = AW'(src); c_dst = AW'(dst); c_len = (AW+1)'(len);
    c_fill = DW'(fill); c_start = 1;
    obs_q.delete();
    o_done_k = -1; o_err = -1; o_busy1 = -1; o_busy_done = -1; o_clk_bad = 0; o_res = 'x;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (k == 1) o_busy1 = busy;
      if (mem_clken !== busy) o_clk_bad++;
      if (mem_chipselect)
        obs_q.push_back('{k, int'(mem_address), mem_write, mem_write ? int'(mem_writedata) : 0});
      if (done) begin
        o_done_k = k; o_err = error; o_res = result; o_busy_done = busy;
        break;
      end
      // Command inputs wander while busy; only the latched copy may matter.
      c_start = (k == restart_at);
      c_abort = (k == abort_at);
      c_mode = 2'($urandom); c_src = AW'($urandom); c_dst = AW'($urandom);
      c_len = (AW+1)'($urandom); c_fill = DW'($urandom);
    end
    c_start = 0; c_abort = 0;
  endtask

  function automatic int trace_diff();
    if (obs_q.size() != exp_q.size()) return 1;
    foreach (obs_q[i])
      if (obs_q[i].k != exp_q[i].k || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].wr != exp_q[i].wr || obs_q[i].data != exp_q[i].data) return 1;
    return 0;
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int a = 0; a < MSZ; a++) if (mem[a] !== refmem[a]) n++;
    return n;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, mem_chipselect, mem_clken, mem_write} !== 6'b0 || result !== '0 ||
        mem_address !== '0 || mem_writedata !== '0) begin
      n_bad++; $display("FAIL reset_outputs: busy=%b done=%b err=%b cs=%b addr=%h res=%h, all must be 0",
                        busy, done, error, mem_chipselect, mem_address, result);
    end
    rst_n = 1;
  endtask

  task automatic test_fill();
    run_job(0, 0, 'h7FFE, 4, 'hA5, 0, 0);
    n_cmp++; if (trace_diff() != 0) begin n_bad++; $display("FAIL fill_trace: %0d accesses, want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (o_done_k !== 5) begin n_bad++; $display("FAIL fill_done: cycle %0d, want 5", o_done_k); end
    n_cmp++; if (o_err !== 0 || o_busy1 !== 1 || o_busy_done !== 0) begin n_bad++; $display("FAIL fill_flags: err=%0d busy1=%0d busy_done=%0d, want 0/1/0", o_err, o_busy1, o_busy_done); end
    n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL fill_mem: %0d words differ, want 0", mem_diff()); end
  endtask

  task automatic test_copy();
    run_job(0, 0, 'h10, 1, 'h11, 0, 0);
    run_job(0, 0, 'h11, 1, 'h22, 0, 0);
    run_job(0, 0, 'h12, 1, 'h33, 0, 0);
    run_job(1, 'h10, 'h100, 3, 0, 0, 0);
    n_cmp++; if (trace_diff() != 0) begin n_bad++; $display("FAIL copy_trace: %0d accesses, want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (obs_q.size() < 6 || obs_q[5].k !== 12 || obs_q[5].data !== 'h33) begin n_bad++; $display("FAIL copy_last_write: size %0d, want write 0x33 in cycle 12", obs_q.size()); end
    n_cmp++; if (o_done_k !== 13 || o_err !== 0) begin n_bad++; $display("FAIL copy_done: cycle %0d err %0d, want 13/0", o_done_k, o_err); end
    n_cmp++; if (mem_diff() !== 0 || o_clk_bad !== 0) begin n_bad++; $display("FAIL copy_mem: %0d words differ, clken bad %0d, want 0/0", mem_diff(), o_clk_bad); end
  endtask

  task automatic test_checksum();
    int nw;
    run_job(0, 0, 0, 3, 'hFF, 0, 0);
    run_job(0, 0, 3, 1, 'h03, 0, 0);
    run_job(2, 0, 0, 4, 0, 0, 0);
    nw = 0;
    foreach (obs_q[i]) if (obs_q[i].wr) nw++;
    n_cmp++; if (o_res !== 16'h0300) begin n_bad++; $display("FAIL sum_result: %h, want 0300", o_res); end
    n_cmp++; if (o_done_k !== 7 || o_err !== 0) begin n_bad++; $display("FAIL sum_done: cycle %0d err %0d, want 7/0", o_done_k, o_err); end
    n_cmp++; if (nw !== 0) begin n_bad++; $display("FAIL sum_nowrite: %0d writes, want 0", nw); end
    n_cmp++; if (trace_diff() != 0) begin n_bad++; $display("FAIL sum_trace: %0d accesses, want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_abort();
    run_job(1, 'h2000, 'h3000, 10, 0, 3, 0);
    n_cmp++; if (o_done_k !== 4 || o_err !== 1) begin n_bad++; $display("FAIL abort_copy_done: cycle %0d err %0d, want 4/1", o_done_k, o_err); end
    n_cmp++; if (trace_diff() != 0 || mem_diff() !== 0) begin n_bad++; $display("FAIL abort_copy_access: %0d accesses (want %0d), %0d words differ", obs_q.size(), exp_q.size(), mem_diff()); end
    run_job(2, 'h40, 0, 5, 0, 6, 0);
    n_cmp++; if (o_done_k !== 7 || o_err !== 1 || o_res !== 16'h0300) begin n_bad++; $display("FAIL abort_drain: cycle %0d err %0d res %h, want 7/1/0300", o_done_k, o_err, o_res); end
    run_job(0, 0, 'h500, 3, 'h77, 3, 0);
    n_cmp++; if (o_done_k !== 4 || o_err !== 1 || trace_diff() != 0) begin n_bad++; $display("FAIL abort_last_fill: cycle %0d err %0d accesses %0d, want 4/1/3", o_done_k, o_err, obs_q.size()); end
  endtask

  task automatic test_errors();
    run_job(3, 0, 0, 5, 0, 0, 0);
    n_cmp++; if (o_done_k !== 1 || o_err !== 1 || obs_q.size() !== 0) begin n_bad++; $display("FAIL err_mode: cycle %0d err %0d accesses %0d, want 1/1/0", o_done_k, o_err, obs_q.size()); end
    repeat (2) @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: error %b, want 1", error); end
    run_job(0, 0, 0, 'h8001, 1, 0, 0);
    n_cmp++; if (o_done_k !== 1 || o_err !== 1 || obs_q.size() !== 0) begin n_bad++; $display("FAIL err_len: cycle %0d err %0d accesses %0d, want 1/1/0", o_done_k, o_err, obs_q.size()); end
    run_job(1, 5, 6, 0, 0, 0, 0);
    n_cmp++; if (o_done_k !== 1 || o_err !== 0 || obs_q.size() !== 0) begin n_bad++; $display("FAIL zero_len: cycle %0d err %0d accesses %0d, want 1/0/0", o_done_k, o_err, obs_q.size()); end
    @(negedge clk); c_abort = 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 0 || done !== 0) begin n_bad++; $display("FAIL idle_abort: busy %b done %b, want 0/0", busy, done); end
    c_abort = 0;
    run_job(0, 0, 'h600, 2, 'h5A, 0, 0);
    n_cmp++; if (o_err !== 0 || o_done_k !== 3 || mem_diff() !== 0) begin n_bad++; $display("FAIL after_idle_abort: err %0d cycle %0d, want 0/3", o_err, o_done_k); end
  endtask

  task automatic test_busy_start();
    run_job(0, 0, 'h700, 6, 'hC3, 0, 2);
    n_cmp++; if (trace_diff() != 0 || o_done_k !== 7) begin n_bad++; $display("FAIL busy_start: %0d accesses cycle %0d, want %0d/7", obs_q.size(), o_done_k, exp_q.size()); end
    n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL busy_start_mem: %0d words differ, want 0", mem_diff()); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    c_mode = 0; c_dst = 'h200; c_len = 20; c_fill = 'h3C; c_start = 1;
    @(negedge clk); c_start = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if ({busy, done, error, mem_chipselect, mem_clken, mem_write} !== 6'b0 || result !== '0 ||
        mem_address !== '0 || mem_writedata !== '0) begin
      n_bad++; $display("FAIL reset_mid: busy=%b cs=%b wr=%b addr=%h res=%h, all must be 0",
                        busy, mem_chipselect, mem_write, mem_address, result);
    end
    refmem['h200] = 'h3C; refmem['h201] = 'h3C;
    ref_res = 0;
    @(negedge clk); rst_n = 1;
    run_job(0, 0, 'h210, 5, 'h81, 0, 0);
    n_cmp++; if (trace_diff() != 0 || o_done_k !== 6 || o_err !== 0) begin n_bad++; $display("FAIL post_reset_job: cycle %0d err %0d, want 6/0", o_done_k, o_err); end
    n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL post_reset_mem: %0d words differ, want 0", mem_diff()); end
  endtask

  task automatic test_random();
    int mode, src, dst, len, ab;
    for (int j = 0; j < 16; j++) begin
      mode = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      len  = $urandom_range(0, 12);
      src  = $urandom_range(0, 1) ? MSZ - 1 - $urandom_range(0, 6) : $urandom_range(0, MSZ - 1);
      dst  = $urandom_range(0, 1) ? MSZ - 1 - $urandom_range(0, 6) : $urandom_range(0, MSZ - 1);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len * (RL + 2) + 1) : 0;
      run_job(mode, src, dst, len, $urandom_range(0, 255), ab, 0);
      n_cmp++; if (trace_diff() != 0) begin n_bad++; $display("FAIL rnd%0d_trace: %0d accesses, want %0d", j, obs_q.size(), exp_q.size()); end
      n_cmp++; if (o_done_k !== e_done_k) begin n_bad++; $display("FAIL rnd%0d_done: cycle %0d, want %0d", j, o_done_k, e_done_k); end
      n_cmp++; if (o_err !== e_err) begin n_bad++; $display("FAIL rnd%0d_err: %0d, want %0d", j, o_err, e_err); end
      n_cmp++; if (o_res !== ref_res) begin n_bad++; $display("FAIL rnd%0d_result: %h, want %h", j, o_res, ref_res); end
      n_cmp++; if (mem_diff() !== 0 || o_clk_bad !== 0) begin n_bad++; $display("FAIL rnd%0d_mem: %0d words differ, clken bad %0d, want 0/0", j, mem_diff(), o_clk_bad); end
    end
  endtask

  initial begin
    for (int a = 0; a < MSZ; a++) refmem[a] = init_val(a);
    test_reset();
    test_fill();
    test_copy();
    test_checksum();
    test_abort();
    test_errors();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/onchip_mem_dma.md
# onchip_mem_dma

Parametrised memory-port engine that drives the FPGA-side slave port of the on-chip frame memory. It performs FILL, COPY and CHECKSUM jobs over a contiguous word range, under a start/busy/done command handshake issued from the HPS PIO control path. It is the generalised successor of the fixed 15-bit-address / 8-bit-data direct port wiring: address width, data width, read latency and checksum width are parameters, and it adds abort and error reporting.

## Interface
- `ADDR_W`, 15, memory word-address width.
- `DATA_W`, 8, memory data width.
- `RD_LAT`, 2, memory read latency in cycles (1..4).
- `SUM_W`, 16, checksum accumulator width (≥ DATA_W).

Ports:
- `clk_clk`  in  1  sole clock; all logic on the rising edge.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `cmd_start`  in  1  job request; sampled only in IDLE.
- `cmd_mode`  in  2  job type: 0 = FILL, 1 = COPY, 2 = CHECKSUM, 3 = illegal.
- `cmd_src`  in  ADDR_W  source base address (COPY, CHECKSUM).
- `cmd_dst`  in  ADDR_W  destination base address (FILL, COPY).
- `cmd_len`  in  ADDR_W+1  word count; 0 is legal.
- `cmd_fill`  in  DATA_W  FILL constant.
- `cmd_abort`  in  1  stop the running job.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse at job end, including abort and error ends.
- `error`  out  1  sticky; cleared by the next accepted start.
- `result`  out  SUM_W  last checksum; holds its value until the next CHECKSUM job starts.
- `mem_address`  out  ADDR_W  memory port address.
- `mem_chipselect`  out  1  access strobe.
- `mem_clken`  out  1  memory clock enable.
- `mem_write`  out  1  1 = write, 0 = read.
- `mem_writedata`  out  DATA_W  write data.
- `mem_readdata`  in  DATA_W  read data.

## Operation
- **Reset:** all outputs 0; state IDLE.
- **States:** IDLE, FILL, CP_RD, CP_WAIT, CP_WR, SUM, DRAIN, END.
- **Start acceptance:** `cmd_start`=1 in IDLE latches all `cmd_*` inputs and clears `error`. A start while busy is ignored.
- **Error end:**
  - An illegal mode, or `cmd_len` > 2^ADDR_W, goes directly to END with `error`=1.
  - No memory access is made.
- **Zero length:** `cmd_len`=0 goes to END with no access and `error`=0.
- **Address wrap:** addresses are base+i modulo 2^ADDR_W.
- **FILL:**
  - One write per cycle: `mem_address`=dst+i, `mem_writedata`=fill.
  - Go to END after word N-1.
- **COPY:** strictly sequential, forward order; overlapping ranges are not corrected.
  - CP_RD issues a read at src+i.
  - CP_WAIT lasts RD_LAT cycles.
  - Read data is captured into a register at the end of the last wait cycle.
  - CP_WR writes the captured data to dst+i.
- **CHECKSUM:**
  - One read per cycle at src+i.
  - A RD_LAT-deep valid shift register tracks reads in flight.
  - The accumulator adds `mem_readdata` (zero-extended) modulo 2^SUM_W for each valid return.
  - After the last issue, DRAIN waits until the pipe is empty.
  - The accumulator is cleared at start; `result` is updated from it on entry to END.
- **Memory strobes:**
  - `mem_chipselect`=1 only in access cycles.
  - `mem_clken`=1 whenever busy; 0 in IDLE.
- **Abort:**
  - `cmd_abort`=1 while busy: no further access is issued from the next cycle.
  - In-flight read data is discarded.
  - Go to END with `error`=1; `result` is not updated.
  - Abort in IDLE is ignored.
  - Abort in the same cycle as the final access: the access completes and the job ends with `error`=1.
- **END:** lasts one cycle with `done`=1 and `busy`=0, then returns to IDLE.

## Timing
- Start accepted at edge of cycle t: `busy`=1 from cycle t+1; first access in cycle t+1.
- FILL, N words: writes in cycles t+1..t+N; `done` in cycle t+N+1.
- COPY: word k read in cycle t+1+k(RD_LAT+2), written in cycle t+2+RD_LAT+k(RD_LAT+2); `done` in cycle t+1+N(RD_LAT+2).
- CHECKSUM: reads in cycles t+1..t+N, last data in cycle t+N+RD_LAT; `done` and new `result` in cycle t+N+RD_LAT+1.
- Zero-length or error job: `done` in cycle t+1.
- A new start is accepted from the cycle after `done`.
- Reset mid-job forces IDLE immediately; outputs go to 0 and `result` is cleared.

## Test plan
- FILL, dst=0x7FFE, len=4, fill=0xA5 -> writes to 0x7FFE, 0x7FFF, 0x0000, 0x0001; `done` in cycle t+5; `error`=0.
- COPY, RD_LAT=2, src=0x0010, dst=0x0100, len=3, memory holds 11/22/33 -> writes 0x11, 0x22, 0x33 at 0x0100..0x0102 in cycles t+4, t+8, t+12; `done` in cycle t+13.
- CHECKSUM, src=0, len=4, data FF/FF/FF/03 -> `result`=0x0300; `done` in cycle t+7; no write strobe.
- Abort in cycle t+3 of a COPY with len=10 -> no chipselect from cycle t+4; `done`+`error` in cycle t+4; destination beyond word 0 unchanged.
- mode=3 or len=0x8001 -> `done`+`error` in cycle t+1, no access. len=0 -> `done` only, no access, `error`=0.
- Start asserted while busy is ignored. Reset asserted mid-FILL -> all outputs 0 asynchronously. Next start after reset runs normally.
